regfile_write_scheduler: RTL and testbench

- Sits between the SEQ writeback stage and a single-write-port register file.
- Accepts up to two write requests per cycle (E-port dstE/valE and M-port dstM/valM), buffers them in order in a small FIFO, and retires one write per cycle onto the register file port.
- Publishes a per-register pending mask and youngest-value forwarding for two decode source ports, so decode can bypass writes that have not yet retired.

---
 rtl/regfile_write_scheduler.sv | 144 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Buffers up to two writeback requests per cycle (E then M) in an in-order
//   FIFO and retires one entry per cycle onto a single-write-port register
//   file. Publishes a per-register pending mask and youngest-value forwarding
//   for two decode source ports.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   wb_valid, dstE/valE,       writeback request; dst 4'hF means "no write"
//   dstM/valM
//   wb_ready                   room for a dual request (combinational on count)
//   rf_wen/rf_waddr/rf_wdata   register file write port, driven from FIFO head
//   srcA, srcB                 decode lookup addresses
//   fwdA_hit/fwdA_val,         youngest buffered value for srcA / srcB
//   fwdB_hit/fwdB_val
//   pending                    bit i set while any buffered entry targets reg i
//   count                      occupied entries
module regfile_write_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REG_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  input  logic [3:0]                 dstE,
  input  logic [REG_W-1:0]           valE,
  input  logic [3:0]                 dstM,
  input  logic [REG_W-1:0]           valM,
  output logic                       wb_ready,
  output logic                       rf_wen,
  output logic [3:0]                 rf_waddr,
  output logic [REG_W-1:0]           rf_wdata,
  input  logic [3:0]                 srcA,
  input  logic [3:0]                 srcB,
  output logic                       fwdA_hit,
  output logic [REG_W-1:0]           fwdA_val,
  output logic                       fwdB_hit,
  output logic [REG_W-1:0]           fwdB_val,
  output logic [14:0]                pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned NREGS = 15;
  localparam logic [3:0]  NONE  = 4'hF;

  logic [3:0]       dst_q  [DEPTH];
  logic [REG_W-1:0] data_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             push_e;
  logic             push_m;
  logic             pop;
  logic [PW-1:0]    m_slot;
  logic [CW-1:0]    cnt_next;

  // Entries listed oldest (k=0) to youngest, with their liveness.
  logic [PW-1:0]    ord_idx   [DEPTH];
  logic [DEPTH-1:0] ord_valid;

  assign count    = cnt_q;
  assign wb_ready = (CW'(DEPTH) - cnt_q) >= CW'(2);

  assign accept   = wb_valid && wb_ready;
  assign push_e   = accept && (dstE != NONE);
  assign push_m   = accept && (dstM != NONE);
  assign pop      = (cnt_q != CW'(0));
  // M lands right behind E when both push, so E is always older.
  assign m_slot   = tail_q + PW'(push_e);
  assign cnt_next = cnt_q + CW'(push_e) + CW'(push_m) - CW'(pop);

  // Head drives the register file port directly.
  assign rf_wen   = pop;
  assign rf_waddr = pop ? dst_q[head_q]  : NONE;
  assign rf_wdata = pop ? data_q[head_q] : '0;

  // Age ordering of the circular buffer.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_idx[k]   = head_q + PW'(k);
      ord_valid[k] = CW'(k) < cnt_q;
    end
  end

  // Pending mask over live entries.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ord_valid[k] && (dst_q[ord_idx[k]] == 4'(r))) begin
          pending[r] = 1'b1;
        end
      end
    end
  end

  // Forwarding: scan oldest to youngest so the last match is the youngest.
  always_comb begin
    fwdA_hit = 1'b0;
    fwdA_val = '0;
    fwdB_hit = 1'b0;
    fwdB_val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && (srcA != NONE) && (dst_q[ord_idx[k]] == srcA)) begin
        fwdA_hit = 1'b1;
        fwdA_val = data_q[ord_idx[k]];
      end
      if (ord_valid[k] && (srcB != NONE) && (dst_q[ord_idx[k]] == srcB)) begin
        fwdB_hit = 1'b1;
        fwdB_val = data_q[ord_idx[k]];
      end
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_q + PW'(pop);
      tail_q <= tail_q + PW'(push_e) + PW'(push_m);
      cnt_q  <= cnt_next;
    end
  end

  // Entry storage; liveness is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_e) begin
      dst_q[tail_q]  <= dstE;
      data_q[tail_q] <= valE;
    end
    if (push_m) begin
      dst_q[m_slot]  <= dstM;
      data_q[m_slot] <= valM;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Testbench for regfile_write_scheduler: table of per-cycle vectors (inputs
// plus expected pre-edge outputs) and a hand sequence for an asynchronous
// reset landing mid-cycle during a drain.
module tb_regfile_write_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned REG_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wb_valid = 1'b0;
  logic [3:0]       dstE = 4'hF;
  logic [REG_W-1:0] valE = '0;
  logic [3:0]       dstM = 4'hF;
  logic [REG_W-1:0] valM = '0;
  logic [3:0]       srcA = 4'hF;
  logic [3:0]       srcB = 4'hF;
  logic             wb_ready;
  logic             rf_wen;
  logic [3:0]       rf_waddr;
  logic [REG_W-1:0] rf_wdata;
  logic             fwdA_hit;
  logic [REG_W-1:0] fwdA_val;
  logic             fwdB_hit;
  logic [REG_W-1:0] fwdB_val;
  logic [14:0]      pending;
  logic [2:0]       count;

  regfile_write_scheduler #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wb_ready(wb_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .srcA(srcA), .srcB(srcB),
    .fwdA_hit(fwdA_hit), .fwdA_val(fwdA_val),
    .fwdB_hit(fwdB_hit), .fwdB_val(fwdB_val),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        wen;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic [14:0] pend;
    logic [2:0]  cnt;
    logic        rdy;
    logic        ha;
    logic [63:0] va;
    logic        hb;
    logic [63:0] vb;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(
    logic rst, logic v, logic [3:0] de, logic [63:0] ve, logic [3:0] dm,
    logic [63:0] vm, logic [3:0] sa, logic [3:0] sb,
    logic wen, logic [3:0] wa, logic [63:0] wd, logic [14:0] pend,
    logic [2:0] cnt, logic rdy, logic ha, logic [63:0] va,
    logic hb, logic [63:0] vb);
    vec_t t;
    t.rst = rst; t.v = v; t.de = de; t.ve = ve; t.dm = dm; t.vm = vm;
    t.sa = sa; t.sb = sb; t.wen = wen; t.wa = wa; t.wd = wd; t.pend = pend;
    t.cnt = cnt; t.rdy = rdy; t.ha = ha; t.va = va; t.hb = hb; t.vb = vb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  localparam logic [63:0] V1 = 64'h768bc9eab567cd74;
  localparam logic [63:0] A1 = 64'hA1, A2 = 64'hA2, B1 = 64'hB1, B2 = 64'hB2;
  localparam logic [63:0] C1 = 64'hC1, C2 = 64'hC2;
  localparam logic [63:0] D1 = 64'hD1, D2 = 64'hD2, D3 = 64'hD3, D4 = 64'hD4;

  initial begin
    // Expected columns describe the state before that vector's clock edge.
    //              rst v de    ve      dm    vm     sa    sb    wen wa    wd      pend     cnt  rdy ha va     hb vb
    vecs.push_back(mk(0,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(0,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    // Single E write; same-cycle request is not forwarded
    vecs.push_back(mk(1,1,4'h0,V1,     4'hF,64'h0, 4'h0,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h0,4'hF, 1,4'h0,V1,     15'h1,  3'd1,1, 1,V1,    0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h0,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    // Same-register dual: E then M, M is youngest
    vecs.push_back(mk(1,1,4'h4,64'h8,  4'h4,64'h1234,4'h4,4'hF,0,4'hF,64'h0, 15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h4,4'h4, 1,4'h4,64'h8,  15'h10, 3'd2,1, 1,64'h1234,1,64'h1234));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h4,4'hF, 1,4'h4,64'h1234,15'h10,3'd1,1, 1,64'h1234,0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    // No-op request
    vecs.push_back(mk(1,1,4'hF,64'h55, 4'hF,64'h66,4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    // Backpressure: three dual requests, the third held once
    vecs.push_back(mk(1,1,4'h1,A1,     4'h2,A2,    4'h1,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,1,4'h1,B1,     4'h2,B2,    4'h1,4'hF, 1,4'h1,A1,     15'h6,  3'd2,1, 1,A1,    0,64'h0));
    vecs.push_back(mk(1,1,4'h1,C1,     4'h2,C2,    4'h1,4'h2, 1,4'h2,A2,     15'h6,  3'd3,0, 1,B1,    1,B2));
    vecs.push_back(mk(1,1,4'h1,C1,     4'h2,C2,    4'h1,4'hF, 1,4'h1,B1,     15'h6,  3'd2,1, 1,B1,    0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h1,4'hF, 1,4'h2,B2,     15'h6,  3'd3,0, 1,C1,    0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h2,4'h1, 1,4'h1,C1,     15'h6,  3'd2,1, 1,C2,    1,C1));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h1,4'hF, 1,4'h2,C2,     15'h4,  3'd1,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    // Fill to 3, then reset between edges
    vecs.push_back(mk(1,1,4'h5,D1,     4'h6,D2,    4'hF,4'hF, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,1,4'h7,D3,     4'h8,D4,    4'hF,4'hF, 1,4'h5,D1,     15'h60, 3'd2,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h8,4'h6, 1,4'h6,D2,     15'h1C0,3'd3,0, 1,D4,    1,D2));
    vecs.push_back(mk(0,0,4'hF,64'h0,  4'hF,64'h0, 4'h8,4'h6, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h8,4'h6, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));
    vecs.push_back(mk(1,0,4'hF,64'h0,  4'hF,64'h0, 4'h8,4'h6, 0,4'hF,64'h0,  15'h0,  3'd0,1, 0,64'h0, 0,64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst;
      wb_valid = vecs[i].v;
      dstE     = vecs[i].de;
      valE     = vecs[i].ve;
      dstM     = vecs[i].dm;
      valM     = vecs[i].vm;
      srcA     = vecs[i].sa;
      srcB     = vecs[i].sb;
      #1;
      chk($sformatf("v%0d.rf_wen", i),   64'(rf_wen),   64'(vecs[i].wen));
      chk($sformatf("v%0d.rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].wa));
      chk($sformatf("v%0d.rf_wdata", i), rf_wdata,      vecs[i].wd);
      chk($sformatf("v%0d.pending", i),  64'(pending),  64'(vecs[i].pend));
      chk($sformatf("v%0d.count", i),    64'(count),    64'(vecs[i].cnt));
      chk($sformatf("v%0d.wb_ready", i), 64'(wb_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d.fwdA_hit", i), 64'(fwdA_hit), 64'(vecs[i].ha));
      chk($sformatf("v%0d.fwdA_val", i), fwdA_val,      vecs[i].va);
      chk($sformatf("v%0d.fwdB_hit", i), 64'(fwdB_hit), 64'(vecs[i].hb));
      chk($sformatf("v%0d.fwdB_val", i), fwdB_val,      vecs[i].vb);
    end

    // Hand sequence: asynchronous reset asserted mid-cycle during a drain.
    @(negedge clk);
    wb_valid = 1'b1; dstE = 4'h3; valE = 64'h33; dstM = 4'h9; valM = 64'h99;
    srcA = 4'hF; srcB = 4'hF;
    @(negedge clk);
    dstE = 4'hA; valE = 64'hAA; dstM = 4'hB; valM = 64'hBB;
    @(negedge clk);
    wb_valid = 1'b0; dstE = 4'hF; dstM = 4'hF;
    #1;
    chk("hs.count_full", 64'(count), 64'd3);
    chk("hs.pending_full", 64'(pending), 64'(15'h0E00));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("hs.rst_wen", 64'(rf_wen), 64'd0);
    chk("hs.rst_pending", 64'(pending), 64'd0);
    chk("hs.rst_count", 64'(count), 64'd0);
    chk("hs.rst_waddr", 64'(rf_waddr), 64'hF);
    @(posedge clk);
    #1;
    chk("hs.rst_hold_wen", 64'(rf_wen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hs.post_wen%0d", c), 64'(rf_wen), 64'd0);
      chk($sformatf("hs.post_count%0d", c), 64'(count), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
